// File: rtl/key_pkg.sv
// Shared constants, types and helpers for the push-button front-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_pkg;

  // Bit positions of the four board keys on every 4-bit key bus
  localparam int KEY_EDIT  = 0;
  localparam int KEY_SWI   = 1;
  localparam int KEY_PLUS  = 2;
  localparam int KEY_MINUS = 3;
  localparam int NUM_KEYS  = 4;

  // Length of the synthetic release inserted between auto-repeats
  localparam int GAP_CYC = 2;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    GAP,
    RATE
  } rep_state_t;

  // Convert a millisecond interval into clock cycles at the given frequency
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, stability counter, debounced level and press strobe.
// Latency: clean raw edge -> level at edge DB_CYC+2; press strobe one cycle after the level falls.
// Backpressure: none; outputs are free-running level and strobe.
module key_debounce_cell #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press,
  output logic fall
);

  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain; idle (released) is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DB_CYC consecutive differing samples; any agreement restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // High for the one cycle right after the debounced level has dropped
  assign fall = stable_d & ~stable;

  // Registered press strobe: lands the cycle after the debounced fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_d <= 1'b1;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= fall;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounced active-low key levels and press strobes for KEY0..KEY3; auto-repeat on Plus/Minus under KEY_AUTO_REPEAT_EN.
// Latency: level follows a clean pin edge after DB_CYC+2 cycles; press strobe one cycle later.
// Backpressure: none; levels and single-cycle strobes, consumer must sample every cycle.
module key_conditioner
  import key_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_raw,
  output logic [3:0] key_level,
  output logic [3:0] key_press
);

  localparam int DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

  logic [3:0] stable;
  logic [3:0] cell_press;
  logic [3:0] fall;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
    key_debounce_cell #(
      .DB_CYC(DB_CYC)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (key_raw[i]),
      .stable(stable[i]),
      .press (cell_press[i]),
      .fall  (fall[i])
    );
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RD_CYC = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RR_CYC = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
  localparam int RMAX   = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int RW     = $clog2(RMAX + 1);

  logic [1:0] rep_gap;
  logic [1:0] rep_pulse;
  logic [1:0] unused_fall;

  assign unused_fall = fall[1:0];

  for (genvar r = 0; r < 2; r++) begin : g_rep
    localparam int K = KEY_PLUS + r;
    localparam logic [3:0] OWN = 4'(1 << K);

    rep_state_t    state;
    logic [RW-1:0] rcnt;
    logic          gap_q;
    logic          pulse_q;
    logic          other_low;
    logic          abort;

    // Another key held down or this key released ends the repeat sequence
    assign other_low = |(~stable & ~OWN);
    assign abort     = stable[K] | other_low;

    // Repeat sequencer: hold delay, then 2-cycle synthetic release + strobe at a fixed rate
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        rcnt    <= '0;
        gap_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          IDLE: begin
            if (fall[K] && !other_low) begin
              state <= DELAY;
              rcnt  <= '0;
            end
          end
          DELAY: begin
            if (abort) begin
              state <= IDLE;
            end else if (rcnt == RW'(RD_CYC - 1)) begin
              state <= GAP;
              rcnt  <= '0;
              gap_q <= 1'b1;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
          GAP: begin
            if (abort) begin
              state <= IDLE;
              gap_q <= 1'b0;
            end else if (rcnt == RW'(GAP_CYC - 1)) begin
              state   <= RATE;
              rcnt    <= '0;
              gap_q   <= 1'b0;
              pulse_q <= 1'b1;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
          RATE: begin
            if (abort) begin
              state <= IDLE;
            end else if (rcnt == RW'(RR_CYC - 1)) begin
              state <= GAP;
              rcnt  <= '0;
              gap_q <= 1'b1;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
          default: begin
            state <= IDLE;
            gap_q <= 1'b0;
          end
        endcase
      end
    end

    assign rep_gap[r]   = gap_q;
    assign rep_pulse[r] = pulse_q;
  end

  assign key_level = stable | {rep_gap, 2'b00};
  assign key_press = cell_press | {rep_pulse, 2'b00};
`else
  logic [3:0] unused_fall;

  assign unused_fall = fall;
  assign key_level   = stable;
  assign key_press   = cell_press;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed scenarios then randomized key activity against a behavioural model.
// Expected outputs are queued by the driver after each clock edge and compared by a monitor on the falling edge.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 5;
  localparam int GP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key_level;
  logic [3:0] key_press;

  always #5 clk = ~clk;

  key_conditioner #(
    .CLK_HZ         (1000),
    .DEBOUNCE_MS    (4),
    .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_raw  (key_raw),
    .key_level(key_level),
    .key_press(key_press)
  );

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model state
  logic [3:0] m_s1, m_s2;          // pin value delayed by one and two edges
  logic [3:0] m_hist[DB];          // last DB synchronised samples, [0] newest
  logic [3:0] m_stable;
  logic [3:0] m_fell;              // debounced level dropped at the last edge
  logic [3:0] m_press, m_gap, m_pulse;
  bit   [3:0] m_alive;             // repeat sequence running for this key
  int         m_t[4];              // edges since this key's press strobe

  task automatic model_reset();
    m_s1 = 4'hF;
    m_s2 = 4'hF;
    for (int j = 0; j < DB; j++) m_hist[j] = 4'hF;
    m_stable = 4'hF;
    m_fell   = 4'h0;
    m_press  = 4'h0;
    m_gap    = 4'h0;
    m_pulse  = 4'h0;
    m_alive  = 4'h0;
    for (int k = 0; k < 4; k++) m_t[k] = 0;
  endtask

  // Advance the model by one clock edge using the pin value the DUT just sampled
  task automatic model_edge();
    logic [3:0] stable_pre;
    logic [3:0] fell_pre;
    logic [3:0] s2_pre;
    bit         all_diff;
    stable_pre = m_stable;
    fell_pre   = m_fell;
    s2_pre     = m_s2;
    m_press    = fell_pre;
    m_gap      = 4'h0;
    m_pulse    = 4'h0;
`ifdef KEY_AUTO_REPEAT_EN
    for (int k = 2; k < 4; k++) begin
      logic [3:0] own;
      bit         others_high;
      own         = 4'b0001 << k;
      others_high = &(stable_pre | own);
      if (fell_pre[k]) begin
        m_alive[k] = others_high;
        m_t[k]     = 0;
      end else if (m_alive[k]) begin
        m_alive[k] = !stable_pre[k] && others_high;
        m_t[k]     = m_t[k] + 1;
      end
      if (m_alive[k]) begin
        m_gap[k]   = (m_t[k] >= RD) && (((m_t[k] - RD) % (GP + RR)) < GP);
        m_pulse[k] = (m_t[k] >= RD + GP) && (((m_t[k] - RD - GP) % (GP + RR)) == 0);
      end
    end
`endif
    for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = s2_pre;
    m_fell    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) if (m_hist[j][i] == stable_pre[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[i] = ~stable_pre[i];
        m_fell[i]   = stable_pre[i];
      end
    end
    m_s2 = m_s1;
    m_s1 = key_raw;
  endtask

  // One clock cycle of stimulus: model the edge, apply reset choice, queue expectation, drive next pins
  task automatic step(input logic [3:0] raw_next, input logic rst_next);
    exp_t e;
    @(posedge clk);
    #1;
    if (reset) model_edge();
    reset = rst_next;
    if (!rst_next) model_reset();
    e.level = m_stable | m_gap;
    e.press = m_press | m_pulse;
    expq.push_back(e);
    key_raw = raw_next;
  endtask

  task automatic hold(input logic [3:0] raw_v, input int n);
    repeat (n) step(raw_v, 1'b1);
  endtask

  // Monitor: compare every queued expectation against the DUT away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        n_checks++;
        if (key_level === mon_e.level) n_pass++;
        else $display("FAIL key_level t=%0t got=%b want=%b", $time, key_level, mon_e.level);
        n_checks++;
        if (key_press === mon_e.press) n_pass++;
        else $display("FAIL key_press t=%0t got=%b want=%b", $time, key_press, mon_e.press);
      end
    end
  end

  int         p_tab[6];
  logic [3:0] r;
  logic       rst_v;

  initial begin
    reset   = 1'b0;
    key_raw = 4'h0;
    model_reset();
    p_tab = '{3, 8, 20, 60, 60, 120};

    // Reset held with all pins low, then release: levels fall 6 edges later
    repeat (3) step(4'h0, 1'b0);
    hold(4'h0, 12);
    hold(4'hF, 10);
    // Clean Edit press
    hold(4'b1110, 12);
    hold(4'hF, 10);
    // Bouncy Swi: 3 low, 1 high, 3 low -> no level change
    hold(4'b1101, 3);
    hold(4'hF, 1);
    hold(4'b1101, 3);
    hold(4'hF, 10);
    // Plus and Minus together
    hold(4'b0011, 12);
    hold(4'hF, 10);
    // Plus held long
    hold(4'b1011, 46);
    hold(4'hF, 12);
    // Plus into RATE, then Edit pressed
    hold(4'b1011, 26);
    hold(4'b1010, 20);
    hold(4'hF, 12);
    // Minus into DELAY, then reset
    hold(4'b0111, 14);
    repeat (2) step(4'b0111, 1'b0);
    hold(4'hF, 10);

    // Randomized activity: progressively longer holds, later segments isolate Plus/Minus
    for (int seg = 0; seg < 6; seg++) begin
      repeat (250) begin
        r = key_raw;
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, p_tab[seg] - 1) == 0) r[i] = ~r[i];
        if (seg >= 4) r[1:0] = 2'b11;
        if (seg == 5) r[3] = 1'b1;
        rst_v = ($urandom_range(0, 399) != 0);
        step(r, rst_v);
      end
    end
    hold(4'hF, 10);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
